// File: rtl/ksa_prefix_tail_pipe_if.sv
// Operand/result bus between KSA prefix stage 4 and the tail pipeline.
// master is the environment side (upstream producer plus downstream consumer), slave is the tail block.
interface ksa_prefix_tail_pipe_if #(
    parameter int TAG_W = 4
);
    logic             flush_in;
    logic             valid_in;
    logic             ready_out;
    logic [31:0]      g_in;
    logic [31:0]      p_in;
    logic [31:0]      hp_in;
    logic             cin_in;
    logic [TAG_W-1:0] tag_in;
    logic             valid_out;
    logic             ready_in;
    logic [31:0]      sum_out;
    logic             cout_out;
    logic             ovf_out;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output flush_in, valid_in, g_in, p_in, hp_in, cin_in, tag_in, ready_in,
        input  ready_out, valid_out, sum_out, cout_out, ovf_out, tag_out
    );

    modport slave (
        input  flush_in, valid_in, g_in, p_in, hp_in, cin_in, tag_in, ready_in,
        output ready_out, valid_out, sum_out, cout_out, ovf_out, tag_out
    );
endinterface

// File: rtl/ksa_prefix_tail_pipe.sv
// Kogge-Stone prefix levels 5 (span 8) and 6 (span 16) plus sum/carry/overflow,
// behind a one- or two-stage elastic valid/ready pipeline carrying a sideband tag.
module ksa_prefix_tail_pipe #(
    parameter int TAG_W  = 4,
    parameter bit S5_REG = 1'b1
) (
    input logic                   clk,
    input logic                   rst_n,
    ksa_prefix_tail_pipe_if.slave bus
);

    logic [31:0]      g5;
    logic [31:0]      p5;
    logic             unused_p5_low;

    logic [31:0]      s6_g_src;
    logic [31:16]     s6_p_src;
    logic [31:0]      s6_hp_src;
    logic             s6_cin_src;
    logic [TAG_W-1:0] s6_tag_src;
    logic             s6_valid_src;

    logic [31:0]      g6;
    logic [31:0]      sum_nxt;
    logic             cout_nxt;
    logic             ovf_nxt;

    logic             s2_valid;
    logic             s2_adv;
    logic [31:0]      s2_sum;
    logic             s2_cout;
    logic             s2_ovf;
    logic [TAG_W-1:0] s2_tag;

    // Stage 5: black cells at distance 8; the low byte already spans down to bit 0.
    always_comb begin
        g5 = bus.g_in;
        p5 = bus.p_in;
        for (int i = 8; i < 32; i++) begin
            g5[i] = bus.g_in[i] | (bus.p_in[i] & bus.g_in[i-8]);
            p5[i] = bus.p_in[i] & bus.p_in[i-8];
        end
    end

    // Stage 6 never consumes the low-half propagates; only the generates matter there.
    assign unused_p5_low = ^p5[15:0];

    assign s2_adv = ~s2_valid | bus.ready_in;

    generate
        if (S5_REG) begin : g_s1
            logic             s1_valid;
            logic             s1_adv;
            logic [31:0]      s1_g;
            logic [31:16]     s1_p;
            logic [31:0]      s1_hp;
            logic             s1_cin;
            logic [TAG_W-1:0] s1_tag;

            assign s1_adv        = ~s1_valid | s2_adv;
            assign bus.ready_out = s1_adv;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid <= 1'b0;
                end else if (bus.flush_in) begin
                    s1_valid <= 1'b0;
                end else if (s1_adv) begin
                    s1_valid <= bus.valid_in;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_g   <= '0;
                    s1_p   <= '0;
                    s1_hp  <= '0;
                    s1_cin <= 1'b0;
                    s1_tag <= '0;
                end else if (!bus.flush_in && s1_adv && bus.valid_in) begin
                    s1_g   <= g5;
                    s1_p   <= p5[31:16];
                    s1_hp  <= bus.hp_in;
                    s1_cin <= bus.cin_in;
                    s1_tag <= bus.tag_in;
                end
            end

            assign s6_g_src     = s1_g;
            assign s6_p_src     = s1_p;
            assign s6_hp_src    = s1_hp;
            assign s6_cin_src   = s1_cin;
            assign s6_tag_src   = s1_tag;
            assign s6_valid_src = s1_valid;
        end else begin : g_no_s1
            assign bus.ready_out = s2_adv;
            assign s6_g_src      = g5;
            assign s6_p_src      = p5[31:16];
            assign s6_hp_src     = bus.hp_in;
            assign s6_cin_src    = bus.cin_in;
            assign s6_tag_src    = bus.tag_in;
            assign s6_valid_src  = bus.valid_in;
        end
    endgenerate

    // Stage 6: after distance 16 every g6[i] is the full prefix G[i:0], i.e. carry c[i+1].
    always_comb begin
        g6 = s6_g_src;
        for (int i = 16; i < 32; i++) begin
            g6[i] = s6_g_src[i] | (s6_p_src[i] & s6_g_src[i-16]);
        end
    end

    assign sum_nxt  = s6_hp_src ^ {g6[30:0], s6_cin_src};
    assign cout_nxt = g6[31];
    assign ovf_nxt  = g6[30] ^ g6[31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else if (bus.flush_in) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s6_valid_src;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sum  <= '0;
            s2_cout <= 1'b0;
            s2_ovf  <= 1'b0;
            s2_tag  <= '0;
        end else if (!bus.flush_in && s2_adv && s6_valid_src) begin
            s2_sum  <= sum_nxt;
            s2_cout <= cout_nxt;
            s2_ovf  <= ovf_nxt;
            s2_tag  <= s6_tag_src;
        end
    end

    assign bus.valid_out = s2_valid;
    assign bus.sum_out   = s2_sum;
    assign bus.cout_out  = s2_cout;
    assign bus.ovf_out   = s2_ovf;
    assign bus.tag_out   = s2_tag;

endmodule

// File: tb/tb_ksa_prefix_tail_pipe.sv
// Directed bench for the KSA tail pipeline: a ripple model of stages 1-4 feeds the block,
// and every retired result is scored against a + b + cin.
module tb_ksa_prefix_tail_pipe;

    logic clk;
    logic rst_n;

    ksa_prefix_tail_pipe_if #(.TAG_W(4)) bus ();

    ksa_prefix_tail_pipe #(.TAG_W(4), .S5_REG(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks   = 0;
    int          fails    = 0;
    int          accepted = 0;
    int          retired  = 0;
    logic [63:0] expQ[$];
    logic [31:0] curA;
    logic [31:0] curB;
    logic        curCin;
    logic [3:0]  curTag;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] expResult(input logic [31:0] a, input logic [31:0] b,
                                              input logic cin, input logic [3:0] tag);
        logic [32:0] s;
        logic        ovf;
        s   = {1'b0, a} + {1'b0, b} + {32'b0, cin};
        ovf = (a[31] == b[31]) && (s[31] != a[31]);
        return {26'b0, tag, ovf, s[32], s[31:0]};
    endfunction

    // Stages 1-4 reference: ripple each 8-bit (or shorter) span bit by bit.
    task automatic prefix4(input logic [31:0] a, input logic [31:0] b, input logic cin,
                           output logic [31:0] g, output logic [31:0] p);
        logic [31:0] gb;
        logic [31:0] pb;
        logic        gAcc;
        logic        pAcc;
        int          lo;
        gb    = a & b;
        pb    = a ^ b;
        gb[0] = gb[0] | (pb[0] & cin);
        for (int i = 0; i < 32; i++) begin
            lo   = (i >= 7) ? i - 7 : 0;
            gAcc = gb[lo];
            pAcc = pb[lo];
            for (int j = lo + 1; j <= i; j++) begin
                gAcc = gb[j] | (pb[j] & gAcc);
                pAcc = pAcc & pb[j];
            end
            g[i] = gAcc;
            p[i] = pAcc;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic [3:0] tag);
        logic [31:0] g;
        logic [31:0] p;
        prefix4(a, b, cin, g, p);
        bus.g_in     = g;
        bus.p_in     = p;
        bus.hp_in    = a ^ b;
        bus.cin_in   = cin;
        bus.tag_in   = tag;
        bus.valid_in = 1'b1;
        curA   = a;
        curB   = b;
        curCin = cin;
        curTag = tag;
    endtask

    // Scoreboard step on the falling edge, where handshakes for the coming rising edge are settled.
    task automatic monitorCycle();
        logic [63:0] e;
        if (!rst_n) begin
            expQ.delete();
        end else if (bus.flush_in) begin
            expQ.delete();
        end else begin
            if (bus.valid_out && bus.ready_in) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("result", {26'b0, bus.tag_out, bus.ovf_out, bus.cout_out, bus.sum_out}, e);
                    retired++;
                end
            end
            if (bus.valid_in && bus.ready_out) begin
                expQ.push_back(expResult(curA, curB, curCin, curTag));
                accepted++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitorCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        bus.valid_in = 1'b0;
        while (expQ.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        checkOutput(tag, 64'(expQ.size()), 64'd0);
    endtask

    task automatic runDirected(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic [3:0] tag,
                               input logic [31:0] expSum, input logic expCout, input logic expOvf);
        applyStimulus(a, b, cin, tag);
        tick();
        bus.valid_in = 1'b0;
        checkOutput("lat1_vout", 64'(bus.valid_out), 64'd0);
        tick();
        checkOutput("lat2_vout", 64'(bus.valid_out), 64'd1);
        checkOutput("sum", 64'(bus.sum_out), 64'(expSum));
        checkOutput("cout", 64'(bus.cout_out), 64'(expCout));
        checkOutput("ovf", 64'(bus.ovf_out), 64'(expOvf));
        checkOutput("tag", 64'(bus.tag_out), 64'(tag));
        tick();
    endtask

    initial begin
        int accBase;
        int retBase;
        int vHigh;

        rst_n        = 1'b0;
        bus.flush_in = 1'b0;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b1;
        bus.g_in     = '0;
        bus.p_in     = '0;
        bus.hp_in    = '0;
        bus.cin_in   = 1'b0;
        bus.tag_in   = '0;
        curA = '0; curB = '0; curCin = 1'b0; curTag = '0;

        #3;
        checkOutput("rst_vout", 64'(bus.valid_out), 64'd0);
        checkOutput("rst_sum", 64'(bus.sum_out), 64'd0);
        checkOutput("rst_cout", 64'(bus.cout_out), 64'd0);
        checkOutput("rst_ovf", 64'(bus.ovf_out), 64'd0);
        checkOutput("rst_tag", 64'(bus.tag_out), 64'd0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_ready", 64'(bus.ready_out), 64'd1);

        $display("[TB] directed carry/overflow vectors");
        runDirected(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'h1, 32'h0000_0000, 1'b1, 1'b0);
        runDirected(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'h2, 32'h8000_0000, 1'b0, 1'b1);
        runDirected(32'h8000_0000, 32'h8000_0000, 1'b0, 4'h3, 32'h0000_0000, 1'b1, 1'b1);

        $display("[TB] back-to-back stream");
        accBase = accepted;
        retBase = retired;
        vHigh   = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus($urandom(), $urandom(), 1'($urandom_range(0, 1)), 4'(i));
            if (i >= 2 && bus.valid_out) vHigh++;
            tick();
        end
        drain("stream_drain");
        checkOutput("stream_full_rate", 64'(vHigh), 64'd98);
        checkOutput("stream_accepted", 64'(accepted - accBase), 64'd100);
        checkOutput("stream_retired", 64'(retired - retBase), 64'd100);

        $display("[TB] backpressure");
        accBase      = accepted;
        retBase      = retired;
        bus.ready_in = 1'b0;
        applyStimulus(32'h0000_0010, 32'h0000_0020, 1'b0, 4'h1);
        tick();
        applyStimulus(32'h0000_0100, 32'h0000_0200, 1'b1, 4'h2);
        tick();
        applyStimulus(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, 4'h3);
        checkOutput("full_ready", 64'(bus.ready_out), 64'd0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall_vout", 64'(bus.valid_out), 64'd1);
            checkOutput("stall_sum", 64'(bus.sum_out), 64'h30);
            checkOutput("stall_tag", 64'(bus.tag_out), 64'h1);
            tick();
        end
        checkOutput("stall_accepted", 64'(accepted - accBase), 64'd2);
        bus.ready_in = 1'b1;
        tick();
        drain("stall_drain");
        checkOutput("release_accepted", 64'(accepted - accBase), 64'd3);
        checkOutput("release_retired", 64'(retired - retBase), 64'd3);

        $display("[TB] flush with both stages full");
        bus.ready_in = 1'b0;
        applyStimulus(32'h1111_0000, 32'h0000_2222, 1'b0, 4'h4);
        tick();
        applyStimulus(32'h3333_0000, 32'h0000_4444, 1'b0, 4'h5);
        tick();
        bus.flush_in = 1'b1;
        applyStimulus(32'h5555_0000, 32'h0000_6666, 1'b0, 4'h6);
        tick();
        bus.flush_in = 1'b0;
        bus.valid_in = 1'b0;
        checkOutput("flush_vout", 64'(bus.valid_out), 64'd0);
        bus.ready_in = 1'b1;
        tick();
        tick();
        checkOutput("flush_empty", 64'(bus.valid_out), 64'd0);
        runDirected(32'h1234_5678, 32'h1111_1111, 1'b0, 4'h7, 32'h2345_6789, 1'b0, 1'b0);

        $display("[TB] asynchronous reset mid-stream");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'hA000_0000 + 32'(i), 32'h0F00_0000, 1'b0, 4'(i + 8));
            tick();
        end
        bus.valid_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_vout", 64'(bus.valid_out), 64'd0);
        checkOutput("midrst_sum", 64'(bus.sum_out), 64'd0);
        tick();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runDirected(32'h0000_1234, 32'h0000_4321, 1'b1, 4'h9, 32'h0000_5556, 1'b0, 1'b0);

        checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
